// File: rtl/pet_stats_engine.sv
// pet_stats_engine
//   Parametrised wellbeing-stat engine for the virtual-pet core. Holds
//   NUM_STATS saturating stats. On each tick one stat, chosen by the random
//   byte, decays. Care commands arrive over a valid/ready handshake. The block
//   also runs the AWAKE/SLEEP/DEAD lifecycle.
//
// Ports
//   clk, reset       system clock, asynchronous active-high reset
//   random[7:0]      free-running random byte (bits [2:0] select the decaying stat)
//   cmd_valid        command present; cmd_ready is always high
//   cmd_op[1:0]      0=CARE 1=SLEEP 2=WAKE 3=REVIVE
//   cmd_idx[2:0]     target stat for CARE
//   cmd_reject       1-cycle pulse when an accepted command is illegal
//   stats            packed stats, stat i at [i*STAT_W +: STAT_W]
//   low_alarm        per-stat "stat <= LOW_THRESH"
//   state[1:0]       0=AWAKE 1=SLEEP 2=DEAD
//   tick, anim       tick pulse and its half-rate toggle
module pet_stats_engine #(
  parameter int unsigned NUM_STATS    = 5,
  parameter int unsigned STAT_W       = 5,
  parameter int unsigned STAT_MAX     = 15,
  parameter int unsigned STAT_INIT    = 10,
  parameter int unsigned CARE_STEP    = 3,
  parameter int unsigned LOW_THRESH   = 3,
  parameter int unsigned TICK_DIV     = 27000000,
  parameter int unsigned STARVE_TICKS = 4,
  parameter int unsigned ENERGY_IDX   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    random,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [2:0]                    cmd_idx,
  output logic                          cmd_reject,
  output logic [NUM_STATS*STAT_W-1:0]   stats,
  output logic [NUM_STATS-1:0]          low_alarm,
  output logic [1:0]                    state,
  output logic                          tick,
  output logic                          anim
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STV_W = $clog2(STARVE_TICKS + 1);
  localparam int unsigned SUM_W = STAT_W + 1;

  typedef enum logic [1:0] {ST_AWAKE = 2'd0, ST_SLEEP = 2'd1, ST_DEAD = 2'd2} state_e;
  typedef enum logic [1:0] {OP_CARE = 2'd0, OP_SLEEP = 2'd1, OP_WAKE = 2'd2, OP_REVIVE = 2'd3} op_e;

  state_e             state_q, state_d;
  logic [STAT_W-1:0]  stat_q [NUM_STATS];
  logic [STAT_W-1:0]  stat_d [NUM_STATS];
  logic [DIV_W-1:0]   div_q, div_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic               tick_q, tick_d;
  logic               anim_q, anim_d;
  logic               reject_q, reject_d;

  op_e                op;
  logic [2:0]         k;
  logic               wrap, live, care_ok, any_zero;
  logic               dec, inc, care;
  logic [SUM_W-1:0]   sum;
  logic               unused_rnd;

  // Only the low three random bits pick a stat.
  assign unused_rnd = ^random[7:3];
  assign op         = op_e'(cmd_op);
  assign k          = random[2:0];
  assign cmd_ready  = 1'b1;

  always_comb begin
    wrap     = (div_q == DIV_W'(TICK_DIV - 1));
    div_d    = wrap ? '0 : div_q + 1'b1;
    tick_d   = wrap;
    anim_d   = anim_q ^ wrap;
    live     = (state_q != ST_DEAD);
    care_ok  = cmd_valid && (op == OP_CARE) && (state_q == ST_AWAKE) &&
               (32'(cmd_idx) < NUM_STATS);
    state_d  = state_q;
    starve_d = starve_q;
    reject_d = 1'b0;
    any_zero = 1'b0;
    dec      = 1'b0;
    inc      = 1'b0;
    care     = 1'b0;
    sum      = '0;

    if (cmd_valid) begin
      case (op)
        OP_CARE:  if (!care_ok) reject_d = 1'b1;
        OP_SLEEP: if (state_q == ST_AWAKE) state_d = ST_SLEEP; else reject_d = 1'b1;
        OP_WAKE:  if (state_q == ST_SLEEP) state_d = ST_AWAKE; else reject_d = 1'b1;
        default:  ;
      endcase
    end

    // Care, decay and sleep recharge fold into one widened sum, so a
    // coincident care+decay clamps once instead of saturating twice.
    for (int unsigned i = 0; i < NUM_STATS; i++) begin
      dec  = wrap && live && (32'(k) == i) &&
             !((state_q == ST_SLEEP) && (i == ENERGY_IDX));
      inc  = wrap && (state_q == ST_SLEEP) && (i == ENERGY_IDX);
      care = care_ok && (32'(cmd_idx) == i);
      sum  = SUM_W'(stat_q[i]) + (care ? SUM_W'(CARE_STEP) : '0) + SUM_W'(inc);
      if (dec && (sum != '0)) sum = sum - 1'b1;
      if (sum > SUM_W'(STAT_MAX)) sum = SUM_W'(STAT_MAX);
      stat_d[i] = sum[STAT_W-1:0];
      if (stat_d[i] == '0) any_zero = 1'b1;
    end

    if (wrap && live) begin
      starve_d = any_zero ? starve_q + 1'b1 : '0;
      if (any_zero && (32'(starve_q) + 1 == STARVE_TICKS))
        state_d = ST_DEAD;
      else if ((state_q == ST_SLEEP) && (stat_d[ENERGY_IDX] == STAT_W'(STAT_MAX)))
        state_d = ST_AWAKE;
    end

    // REVIVE overrides everything, including a coincident tick's decay.
    if (cmd_valid && (op == OP_REVIVE)) begin
      for (int unsigned i = 0; i < NUM_STATS; i++) stat_d[i] = STAT_W'(STAT_INIT);
      starve_d = '0;
      state_d  = ST_AWAKE;
      reject_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_STATS; i++) stat_q[i] <= STAT_W'(STAT_INIT);
      state_q  <= ST_AWAKE;
      div_q    <= '0;
      starve_q <= '0;
      tick_q   <= 1'b0;
      anim_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_STATS; i++) stat_q[i] <= stat_d[i];
      state_q  <= state_d;
      div_q    <= div_d;
      starve_q <= starve_d;
      tick_q   <= tick_d;
      anim_q   <= anim_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    stats     = '0;
    low_alarm = '0;
    for (int unsigned i = 0; i < NUM_STATS; i++) begin
      stats[i*STAT_W +: STAT_W] = stat_q[i];
      low_alarm[i]              = (stat_q[i] <= STAT_W'(LOW_THRESH));
    end
  end

  assign state      = state_q;
  assign tick       = tick_q;
  assign anim       = anim_q;
  assign cmd_reject = reject_q;

endmodule

// File: tb/tb_pet_stats_engine.sv
// Directed testbench for pet_stats_engine with TICK_DIV=4 and other defaults.
module tb_pet_stats_engine;

  localparam logic [24:0] ALL10 = {5{5'd10}};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  random = 8'hFF;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [2:0]  cmd_idx = 3'd0;
  logic        cmd_reject;
  logic [24:0] stats;
  logic [4:0]  low_alarm;
  logic [1:0]  state;
  logic        tick;
  logic        anim;

  int errors = 0;
  int checks = 0;

  pet_stats_engine #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .random(random), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .cmd_reject(cmd_reject), .stats(stats), .low_alarm(low_alarm),
    .state(state), .tick(tick), .anim(anim)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] st(input int i);
    return stats[i*5 +: 5];
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [2:0] idx);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_idx = idx;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tick_timeout: got no tick, expected one within 8 cycles");
    end
  endtask

  task automatic test_reset();
    logic exp_anim;
    logic exp_tick;
    reset = 1'b1;
    random = 8'hFF;
    step(2);
    checks++; if (stats !== ALL10) begin errors++; $display("FAIL rst_stats: got %h expected %h", stats, ALL10); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b expected 0", tick); end
    checks++; if (anim !== 1'b0) begin errors++; $display("FAIL rst_anim: got %b expected 0", anim); end
    checks++; if (cmd_reject !== 1'b0) begin errors++; $display("FAIL rst_reject: got %b expected 0", cmd_reject); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", cmd_ready); end
    checks++; if (low_alarm !== 5'b0) begin errors++; $display("FAIL rst_alarm: got %b expected 0", low_alarm); end
    reset = 1'b0;
    exp_anim = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      exp_tick = (c % 4 == 0);
      if (exp_tick) exp_anim = ~exp_anim;
      checks++; if (tick !== exp_tick) begin errors++; $display("FAIL tick_cycle%0d: got %b expected %b", c, tick, exp_tick); end
      checks++; if (anim !== exp_anim) begin errors++; $display("FAIL anim_cycle%0d: got %b expected %b", c, anim, exp_anim); end
    end
    checks++; if (stats !== ALL10) begin errors++; $display("FAIL no_decay_k7: got %h expected %h", stats, ALL10); end
  endtask

  task automatic test_decay_care();
    logic [4:0] exp_v;
    do_reset();
    random = 8'h01;
    for (int t = 1; t <= 8; t++) begin
      wait_tick();
      exp_v = 5'(10 - t);
      checks++; if (st(1) !== exp_v) begin errors++; $display("FAIL decay_t%0d: got %0d expected %0d", t, st(1), exp_v); end
      checks++; if (low_alarm[1] !== (exp_v <= 5'd3)) begin errors++; $display("FAIL alarm_t%0d: got %b expected %b", t, low_alarm[1], (exp_v <= 5'd3)); end
    end
    checks++; if ({st(4), st(3), st(2), st(0)} !== {4{5'd10}}) begin errors++; $display("FAIL decay_others: got %h expected all 10", stats); end
    random = 8'hFF;
    send_cmd(2'd0, 3'd1);
    checks++; if (st(1) !== 5'd5) begin errors++; $display("FAIL care1: got %0d expected 5", st(1)); end
    checks++; if (low_alarm !== 5'b0) begin errors++; $display("FAIL care1_alarm: got %b expected 0", low_alarm); end
    checks++; if (cmd_reject !== 1'b0) begin errors++; $display("FAIL care1_reject: got %b expected 0", cmd_reject); end
  endtask

  task automatic test_care_decay_same();
    do_reset();
    random = 8'hFF;
    send_cmd(2'd0, 3'd0);
    checks++; if (st(0) !== 5'd13) begin errors++; $display("FAIL care0_a: got %0d expected 13", st(0)); end
    send_cmd(2'd0, 3'd0);
    checks++; if (st(0) !== 5'd15) begin errors++; $display("FAIL care0_clamp: got %0d expected 15", st(0)); end
    random = 8'h00;
    wait_tick();
    checks++; if (st(0) !== 5'd14) begin errors++; $display("FAIL decay0: got %0d expected 14", st(0)); end
    step(3);
    send_cmd(2'd0, 3'd0);
    random = 8'hFF;
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL coincide_tick: got %b expected 1", tick); end
    checks++; if (st(0) !== 5'd15) begin errors++; $display("FAIL care_decay: got %0d expected 15", st(0)); end
    send_cmd(2'd0, 3'd5);
    checks++; if (cmd_reject !== 1'b1) begin errors++; $display("FAIL idx5_reject: got %b expected 1", cmd_reject); end
    checks++; if (stats !== {5'd10, 5'd10, 5'd10, 5'd10, 5'd15}) begin errors++; $display("FAIL idx5_stats: got %h expected %h", stats, {5'd10, 5'd10, 5'd10, 5'd10, 5'd15}); end
    step(1);
    checks++; if (cmd_reject !== 1'b0) begin errors++; $display("FAIL reject_pulse: got %b expected 0", cmd_reject); end
  endtask

  task automatic test_sleep();
    do_reset();
    random = 8'hFF;
    send_cmd(2'd0, 3'd4);
    random = 8'h04;
    wait_tick();
    checks++; if (st(4) !== 5'd12) begin errors++; $display("FAIL energy_setup: got %0d expected 12", st(4)); end
    send_cmd(2'd1, 3'd0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL sleep_enter: got %0d expected 1", state); end
    checks++; if (cmd_reject !== 1'b0) begin errors++; $display("FAIL sleep_reject: got %b expected 0", cmd_reject); end
    for (int t = 1; t <= 3; t++) begin
      wait_tick();
      checks++; if (st(4) !== 5'(12 + t)) begin errors++; $display("FAIL energy_t%0d: got %0d expected %0d", t, st(4), 12 + t); end
      checks++; if (state !== ((t == 3) ? 2'd0 : 2'd1)) begin errors++; $display("FAIL sleep_state_t%0d: got %0d expected %0d", t, state, (t == 3) ? 0 : 1); end
    end
    random = 8'hFF;
    send_cmd(2'd2, 3'd0);
    checks++; if (cmd_reject !== 1'b1) begin errors++; $display("FAIL wake_awake_reject: got %b expected 1", cmd_reject); end
    checks++; if (stats !== {5'd15, 5'd10, 5'd10, 5'd10, 5'd10}) begin errors++; $display("FAIL sleep_stats: got %h expected %h", stats, {5'd15, 5'd10, 5'd10, 5'd10, 5'd10}); end
  endtask

  task automatic test_starve();
    logic [24:0] frozen;
    frozen = {5'd10, 5'd10, 5'd0, 5'd10, 5'd10};
    do_reset();
    random = 8'h02;
    for (int t = 1; t <= 13; t++) begin
      wait_tick();
      if (t == 12) begin
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL starve_3rd: got %0d expected 0", state); end
        checks++; if (st(2) !== 5'd0) begin errors++; $display("FAIL stat2_zero: got %0d expected 0", st(2)); end
      end
    end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL dead_state: got %0d expected 2", state); end
    wait_tick();
    checks++; if (stats !== frozen) begin errors++; $display("FAIL dead_frozen: got %h expected %h", stats, frozen); end
    checks++; if (low_alarm !== 5'b00100) begin errors++; $display("FAIL dead_alarm: got %b expected 00100", low_alarm); end
    send_cmd(2'd0, 3'd0);
    checks++; if (cmd_reject !== 1'b1) begin errors++; $display("FAIL dead_care_reject: got %b expected 1", cmd_reject); end
    checks++; if (stats !== frozen) begin errors++; $display("FAIL dead_care_stats: got %h expected %h", stats, frozen); end
    send_cmd(2'd1, 3'd0);
    checks++; if (cmd_reject !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL dead_sleep: got reject=%b state=%0d expected reject=1 state=2", cmd_reject, state); end
    send_cmd(2'd3, 3'd0);
    checks++; if (stats !== ALL10) begin errors++; $display("FAIL revive_stats: got %h expected %h", stats, ALL10); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL revive_state: got %0d expected 0", state); end
    checks++; if (cmd_reject !== 1'b0) begin errors++; $display("FAIL revive_reject: got %b expected 0", cmd_reject); end
  endtask

  task automatic test_revive_tick();
    do_reset();
    random = 8'h00;
    wait_tick();
    checks++; if (st(0) !== 5'd9) begin errors++; $display("FAIL rt_decay: got %0d expected 9", st(0)); end
    step(3);
    send_cmd(2'd3, 3'd0);
    random = 8'hFF;
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL rt_tick: got %b expected 1", tick); end
    checks++; if (stats !== ALL10) begin errors++; $display("FAIL rt_stats: got %h expected %h", stats, ALL10); end
  endtask

  task automatic test_reset_mid_sleep();
    do_reset();
    random = 8'hFF;
    send_cmd(2'd0, 3'd0);
    send_cmd(2'd1, 3'd0);
    wait_tick();
    checks++; if (state !== 2'd1 || anim !== 1'b1) begin errors++; $display("FAIL pre_reset: got state=%0d anim=%b expected state=1 anim=1", state, anim); end
    step(1);
    reset = 1'b1;
    #2;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL async_state: got %0d expected 0", state); end
    checks++; if (stats !== ALL10) begin errors++; $display("FAIL async_stats: got %h expected %h", stats, ALL10); end
    checks++; if (anim !== 1'b0) begin errors++; $display("FAIL async_anim: got %b expected 0", anim); end
    step(1);
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step(1);
      checks++; if (tick !== (c == 4)) begin errors++; $display("FAIL div_restart_c%0d: got %b expected %b", c, tick, (c == 4)); end
    end
  endtask

  initial begin
    test_reset();
    test_decay_care();
    test_care_decay_same();
    test_sleep();
    test_starve();
    test_revive_tick();
    test_reset_mid_sleep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pet_stats_engine.md
Name: pet_stats_engine

Overview:
- Parametrised stat engine for the virtual-pet core; the next generation of the existing fixed five-stat block.
- Holds NUM_STATS saturating wellbeing stats; decays one randomly selected stat per tick; applies care commands through a valid/ready handshake.
- Runs an AWAKE/SLEEP/DEAD lifecycle with auto-wake, starvation death and revive.
- Feeds the display/animation logic through a packed stat bus, per-stat low alarms and a half-rate animation toggle.

Parameters:
NUM_STATS, 5, number of stats (2..8)
STAT_W, 5, bits per stat
STAT_MAX, 15, saturation ceiling (must be < 2^STAT_W)
STAT_INIT, 10, value loaded at reset and on revive
CARE_STEP, 3, amount added by a CARE command
LOW_THRESH, 3, alarm asserted when stat <= LOW_THRESH
TICK_DIV, 27000000, clk cycles per tick
STARVE_TICKS, 4, consecutive ticks any stat must sit at 0 before death
ENERGY_IDX, 4, index of the energy stat

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
random  in  8  free-running random byte
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when high with cmd_valid
cmd_op  in  2  0=CARE, 1=SLEEP, 2=WAKE, 3=REVIVE
cmd_idx  in  3  target stat for CARE
cmd_reject  out  1  1-cycle pulse: handshake done but command illegal in current state
stats  out  NUM_STATS*STAT_W  packed stats, stat i at [i*STAT_W +: STAT_W]
low_alarm  out  NUM_STATS  stat i <= LOW_THRESH
state  out  2  0=AWAKE, 1=SLEEP, 2=DEAD
tick  out  1  1-cycle pulse per tick
anim  out  1  toggles every tick

Behaviour:
- Reset (async): every stat = STAT_INIT, state = AWAKE, divider = 0, starve counter = 0, tick = 0, anim = 0, cmd_reject = 0.
- cmd_ready = 1 in every state. Accept = cmd_valid & cmd_ready; effects appear on outputs the cycle after accept.
- Divider: counts 0..TICK_DIV-1 and wraps. tick pulses on the cycle the divider wraps. anim toggles on the same cycle.
- Decay on tick, AWAKE: k = random[2:0]. If k < NUM_STATS, stat k decrements, saturating at 0; otherwise no decay.
- Decay on tick, SLEEP: same rule, except when k == ENERGY_IDX. In that case no decay, and energy increments by 1, saturating at STAT_MAX, every tick.
- Decay on tick, DEAD: no decay.
- CARE (AWAKE only): stat[cmd_idx] = min(stat + CARE_STEP, STAT_MAX). Compute in STAT_W+1 bits.
- CARE with cmd_idx >= NUM_STATS is rejected.
- CARE and decay on the same stat in the same cycle: result = clamp(stat - 1 + CARE_STEP, 0, STAT_MAX), evaluated in one expression.
- SLEEP: AWAKE -> SLEEP.
- WAKE: SLEEP -> AWAKE.
- Auto-wake: SLEEP -> AWAKE on the tick that makes energy reach STAT_MAX. If energy is already at STAT_MAX, SLEEP is still accepted and exits on the next tick.
- Any state/op pair other than those listed above, excluding REVIVE, pulses cmd_reject and changes nothing.
- Starvation: on each tick in AWAKE or SLEEP, if any stat == 0 after that tick's update, the starve counter increments; otherwise it clears to 0.
- Death: when the starve counter reaches STARVE_TICKS, state -> DEAD on that tick.
- DEAD: stats freeze and low_alarm stays live. Only REVIVE is legal; every other op is rejected.
- REVIVE: legal in any state. Reloads all stats to STAT_INIT, clears the starve counter, state -> AWAKE. The divider is not cleared.
- REVIVE coincident with a tick: REVIVE wins and that tick's decay is discarded.
- Reset asserted mid-operation overrides everything immediately.
- The block holds no key edge state; the front-end delivers one cmd_valid pulse per button press.

Test Plan:
- Bench parameters: TICK_DIV=4, defaults otherwise.
- Reset, random=0xFF, 40 cycles: stats all 10, tick pulse every 4th cycle, anim toggles, no decay (k=7).
- random=0x01, 8 ticks: stat1 10->2 and low_alarm[1] asserts at 3; CARE idx1 -> stat1 = 5, alarm drops.
- CARE idx0 at 14 on a tick with random=0x00: stat0 = 15 (14-1+3 clamped); CARE idx5 -> cmd_reject pulse, stats unchanged.
- SLEEP with energy=12, random=0x04: energy 13,14,15 on successive ticks, state returns to AWAKE on the third tick. WAKE sent while AWAKE -> cmd_reject.
- random=0x02, drive stat2 to 0, hold 4 ticks: state = DEAD on the 4th zero tick and stats frozen. CARE rejected; REVIVE -> all stats 10, state AWAKE.
- Assert reset mid-SLEEP between ticks: next cycle state AWAKE, stats 10, anim 0, divider restarts from 0.
